mul32_kara_seq: RTL and testbench

Sequencer that computes a 32×32→64-bit unsigned product by time-multiplexing a single shared, pipelined 16×16 Karatsuba multiplier core over four partial products. The block sits between the Montgomery datapath control and the 16-bit multiplier core. It accepts one operand pair per transaction through a valid/ready handshake. It issues the partial products back-to-back and accumulates the returning results, tracking them with a latency-matched tag pipe. It presents the 64-bit result through a valid/ready handshake.

---
 rtl/mul_seq_pkg.sv | 45 ++++
 rtl/mul_tag_pipe.sv | 40 ++++
 rtl/mul32_kara_seq.sv | 134 +++++++++++++
 tb/tb_mul32_kara_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared encodings, widths and helpers for the 32x32 sequencer that
// time-multiplexes a 16x16 multiplier core.
package mul_seq_pkg;

   localparam int HW = 16;
   localparam int FW = 32;
   localparam int PW = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic [1:0] shcode_t;

   localparam shcode_t SH0  = 2'd0;
   localparam shcode_t SH16 = 2'd1;
   localparam shcode_t SH32 = 2'd2;

   typedef struct packed {
      logic    valid;
      shcode_t code;
   } tag_t;

   // Place a returned 32-bit partial product at its weight in the 64-bit sum.
   function automatic logic [PW-1:0] align_pp(input logic [FW-1:0] p, input shcode_t code);
      case (code)
         SH16:    return {16'b0, p, 16'b0};
         SH32:    return {p, 32'b0};
         default: return {32'b0, p};
      endcase
   endfunction

   // Issue index 0..3 walks a0*b0, a1*b0, a0*b1, a1*b1.
   function automatic shcode_t issue_code(input logic [1:0] idx);
      case (idx)
         2'd0:    return SH0;
         2'd3:    return SH32;
         default: return SH16;
      endcase
   endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Latency-matched shift register of {valid, shift code}; the tag leaving the
// last stage lines up with the product the core returns in the same cycle.
module mul_tag_pipe
   import mul_seq_pkg::*;
#(
   parameter int DEPTH = 3
)
(
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage_reg  [DEPTH];
   tag_t stage_next [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_next[gi] = tag_in;
         end else begin : g_body
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            stage_reg[i] <= '0;
         end else begin
            stage_reg[i] <= stage_next[i];
         end
      end
   end

   assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mul32_kara_seq.sv
// 32x32->64 unsigned multiply built from four back-to-back issues to a shared
// pipelined 16x16 core, with returning products summed under tag control.
module mul32_kara_seq
   import mul_seq_pkg::*;
#(
   parameter int MUL_LAT = 3
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [FW-1:0] in_a,
   input  logic [FW-1:0] in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_p,
   output logic [HW-1:0] mul_a,
   output logic [HW-1:0] mul_b,
   input  logic [FW-1:0] mul_p,
   output logic          busy
);

   state_t           state_reg;
   logic [1:0]       cnt_reg;
   logic [1:0]       cnt_next;
   logic [1:0]       acc_cnt_reg;
   logic [FW-1:0]    a_reg;
   logic [FW-1:0]    b_reg;
   logic [PW-1:0]    acc_reg;
   logic [PW-1:0]    acc_next;
   logic [HW-1:0]    mul_a_reg;
   logic [HW-1:0]    mul_b_reg;
   logic [1:0][HW-1:0] a_half;
   logic [1:0][HW-1:0] b_half;
   tag_t             tag_in;
   tag_t             tag_out;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_half
         assign a_half[gi] = a_reg[gi*HW +: HW];
         assign b_half[gi] = b_reg[gi*HW +: HW];
      end
   endgenerate

   // mul_a/mul_b are registered, so the tag describing them is formed from the
   // same state/count registers and travels exactly MUL_LAT stages.
   always_comb begin
      tag_in       = '0;
      tag_in.valid = (state_reg == ST_ISSUE);
      tag_in.code  = issue_code(cnt_reg);
   end

   mul_tag_pipe #(
      .DEPTH (MUL_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign cnt_next = cnt_reg + 2'd1;
   assign acc_next = acc_reg + align_pp(mul_p, tag_out.code);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         acc_cnt_reg <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         acc_reg     <= '0;
         mul_a_reg   <= '0;
         mul_b_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg       <= in_a;
                  b_reg       <= in_b;
                  acc_reg     <= '0;
                  cnt_reg     <= '0;
                  acc_cnt_reg <= '0;
                  mul_a_reg   <= in_a[HW-1:0];
                  mul_b_reg   <= in_b[HW-1:0];
                  state_reg   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // With a short core latency early products return while issuing.
               if (tag_out.valid) begin
                  acc_reg     <= acc_next;
                  acc_cnt_reg <= acc_cnt_reg + 2'd1;
               end
               if (cnt_reg == 2'd3) begin
                  mul_a_reg <= '0;
                  mul_b_reg <= '0;
                  state_reg <= ST_DRAIN;
               end else begin
                  cnt_reg   <= cnt_next;
                  mul_a_reg <= a_half[cnt_next[0]];
                  mul_b_reg <= b_half[cnt_next[1]];
               end
            end
            ST_DRAIN: begin
               if (tag_out.valid) begin
                  acc_reg     <= acc_next;
                  acc_cnt_reg <= acc_cnt_reg + 2'd1;
                  if (acc_cnt_reg == 2'd3) begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign out_p     = acc_reg;
   assign mul_a     = mul_a_reg;
   assign mul_b     = mul_b_reg;

endmodule

// File: tb/tb_mul32_kara_seq.sv
// Bench for mul32_kara_seq: three instances (core latency 3, 1, 8) each paired
// with a behavioural 16x16 core; results checked through an expected-value queue.
module tb_mul32_kara_seq;

   localparam int NL = 3;
   localparam int LATS [NL] = '{3, 1, 8};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [NL];
   logic        in_ready  [NL];
   logic [31:0] in_a      [NL];
   logic [31:0] in_b      [NL];
   logic        out_valid [NL];
   logic        out_ready [NL];
   logic [63:0] out_p     [NL];
   logic [15:0] mul_a     [NL];
   logic [15:0] mul_b     [NL];
   logic [31:0] mul_p     [NL];
   logic        busy      [NL];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          t_acc = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar gi = 0; gi < NL; gi++) begin : g_lane
         logic [31:0] core_pipe [8];

         // Behavioural core: not reset, so in-flight products survive a DUT reset.
         always @(posedge clk) begin
            core_pipe[0] <= {16'b0, mul_a[gi]} * {16'b0, mul_b[gi]};
            for (int k = 1; k < 8; k++) core_pipe[k] <= core_pipe[k-1];
         end
         assign mul_p[gi] = core_pipe[LATS[gi]-1];

         mul32_kara_seq #(
            .MUL_LAT (LATS[gi])
         ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_a      (in_a[gi]),
            .in_b      (in_b[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_p     (out_p[gi]),
            .mul_a     (mul_a[gi]),
            .mul_b     (mul_b[gi]),
            .mul_p     (mul_p[gi]),
            .busy      (busy[gi])
         );
      end
   endgenerate

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input int ln, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] expv);
      int n = 0;
      exp_q.push_back(expv);
      in_a[ln]     = a;
      in_b[ln]     = b;
      in_valid[ln] = 1'b1;
      while (!in_ready[ln] && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (in_ready[ln] !== 1'b1) begin
         errors++;
         $display("FAIL accept lane%0d: in_ready=%b required 1", ln, in_ready[ln]);
      end
      t_acc = cyc;
      step();
      in_valid[ln] = 1'b0;
   endtask

   task automatic finish_txn(input int ln);
      int          n = 0;
      logic [63:0] expv;
      out_ready[ln] = 1'b1;
      while (!out_valid[ln] && n < 60) begin
         step();
         n++;
      end
      checks++;
      if (cyc - t_acc != LATS[ln] + 5) begin
         errors++;
         $display("FAIL latency lane%0d: got %0d cycles required %0d", ln, cyc - t_acc, LATS[ln] + 5);
      end
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (out_p[ln] !== expv) begin
         errors++;
         $display("FAIL product lane%0d: out_p=%h required %h", ln, out_p[ln], expv);
      end
      step();
      checks++;
      if (in_ready[ln] !== 1'b1 || out_valid[ln] !== 1'b0) begin
         errors++;
         $display("FAIL release lane%0d: in_ready=%b out_valid=%b required 1/0",
                  ln, in_ready[ln], out_valid[ln]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int l = 0; l < NL; l++) begin
         in_valid[l]  = 1'b0;
         out_ready[l] = 1'b1;
         in_a[l]      = '0;
         in_b[l]      = '0;
      end
      repeat (4) step();
      rst = 1'b0;
      step();
      for (int l = 0; l < NL; l++) begin
         checks++;
         if (in_ready[l] !== 1'b1 || out_valid[l] !== 1'b0 || busy[l] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl lane%0d: in_ready=%b out_valid=%b busy=%b required 1/0/0",
                     l, in_ready[l], out_valid[l], busy[l]);
         end
         checks++;
         if (out_p[l] !== 64'h0 || mul_a[l] !== 16'h0 || mul_b[l] !== 16'h0) begin
            errors++;
            $display("FAIL reset_data lane%0d: out_p=%h mul_a=%h mul_b=%h required 0",
                     l, out_p[l], mul_a[l], mul_b[l]);
         end
      end
      repeat (5) step();
      checks++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle: in_ready=%b busy=%b required 1/0", in_ready[0], busy[0]);
      end
   endtask

   task automatic test_basic();
      start_txn(0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008);
      checks++;
      if (busy[0] !== 1'b1 || mul_a[0] !== 16'h0002 || mul_b[0] !== 16'h0004) begin
         errors++;
         $display("FAIL first_issue: busy=%b mul_a=%h mul_b=%h required 1/0002/0004",
                  busy[0], mul_a[0], mul_b[0]);
      end
      finish_txn(0);
   endtask

   task automatic test_maximum();
      start_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      finish_txn(0);
      start_txn(0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
      finish_txn(0);
   endtask

   task automatic test_back_to_back();
      logic [63:0] held;
      int          n = 0;
      int          t_hs;
      start_txn(0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
      out_ready[0] = 1'b0;
      while (!out_valid[0] && n < 60) begin
         step();
         n++;
      end
      held = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_p[0] !== held) begin
            errors++;
            $display("FAIL backpressure cyc%0d: out_valid=%b in_ready=%b out_p=%h required 1/0/%h",
                     i, out_valid[0], in_ready[0], out_p[0], held);
         end
         in_valid[0] = 1'b1;
         in_a[0]     = $urandom;
         in_b[0]     = $urandom;
         step();
      end
      out_ready[0] = 1'b1;
      t_hs = cyc;
      start_txn(0, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
      checks++;
      if (t_acc != t_hs + 1) begin
         errors++;
         $display("FAIL b2b_accept: accepted %0d cycles after handshake required 1", t_acc - t_hs);
      end
      finish_txn(0);
   endtask

   task automatic test_reset_drain();
      in_a[0]     = 32'hFFFF_FFFF;
      in_b[0]     = 32'hFFFF_FFFF;
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      repeat (4) step();
      checks++;
      if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_drain: busy=%b out_valid=%b required 1/0", busy[0], out_valid[0]);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_p[0] !== 64'h0) begin
         errors++;
         $display("FAIL drain_reset: in_ready=%b busy=%b out_p=%h required 1/0/0",
                  in_ready[0], busy[0], out_p[0]);
      end
      start_txn(0, 32'h0000_0002, 32'h0000_0003, 64'h6);
      finish_txn(0);
   endtask

   task automatic test_latency_sweep(input int ln);
      logic [31:0] a;
      logic [31:0] b;
      int          prev = 0;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         if (i == 0) begin
            a = 32'hFFFF_FFFF;
            b = 32'hFFFF_FFFF;
         end
         start_txn(ln, a, b, {32'b0, a} * {32'b0, b});
         if (i > 0) begin
            checks++;
            if (t_acc - prev != LATS[ln] + 6) begin
               errors++;
               $display("FAIL throughput lane%0d: period %0d required %0d", ln, t_acc - prev, LATS[ln] + 6);
            end
         end
         prev = t_acc;
         finish_txn(ln);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_maximum();
      test_back_to_back();
      test_reset_drain();
      test_latency_sweep(1);
      test_latency_sweep(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
